// File: rtl/joy_reader.sv
// NES-style serial gamepad scanner: latches both pads, clocks out eight
// buttons each, and publishes them as stable active-high bytes.
module joy_reader #(
    parameter int HALF = 150
) (
    input  logic       clock25,
    input  logic       reset,
    input  logic       poll,
    input  logic       pad1_d,
    input  logic       pad2_d,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       valid,
    output logic       busy
);
    localparam int PW = $clog2(2 * HALF);
    localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF - 1);
    localparam logic [PW-1:0] HALF_LAST  = PW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] phase, phase_next;
    logic [2:0]    n, n_next;
    logic [1:0]    sync1_ff, sync2_ff;
    logic [7:0]    sh1, sh2;
    logic          capture, publish;

    // Pad data is asynchronous; idle-high so a reset synchronizer reads "not pressed".
    always_ff @(posedge clock25) begin
        if (reset) begin
            sync1_ff <= 2'b11;
            sync2_ff <= 2'b11;
        end else begin
            sync1_ff <= {sync1_ff[0], pad1_d};
            sync2_ff <= {sync2_ff[0], pad2_d};
        end
    end

    always_ff @(posedge clock25) begin
        if (reset) begin
            state <= IDLE;
            phase <= '0;
            n     <= '0;
        end else begin
            state <= state_next;
            phase <= phase_next;
            n     <= n_next;
        end
    end

    // Every bit is rewritten each scan, so the shift registers need no reset.
    always_ff @(posedge clock25) begin
        if (capture) begin
            sh1[n] <= ~sync1_ff[1];
            sh2[n] <= ~sync2_ff[1];
        end
    end

    always_ff @(posedge clock25) begin
        if (reset) begin
            joy1 <= 8'h00;
            joy2 <= 8'h00;
        end else if (publish) begin
            joy1 <= sh1;
            joy2 <= sh2;
        end
    end

    // Outputs are loaded on the edge entering DONE so they appear together with valid.
    always_comb begin
        state_next = state;
        phase_next = phase + 1'b1;
        n_next     = n;
        capture    = 1'b0;
        publish    = 1'b0;
        pad_latch  = 1'b0;
        pad_clk    = 1'b1;
        valid      = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy       = 1'b0;
                phase_next = '0;
                if (poll) begin
                    state_next = LATCH;
                    n_next     = '0;
                end
            end
            LATCH: begin
                pad_latch = 1'b1;
                if (phase == LATCH_LAST) begin
                    state_next = LOW;
                    phase_next = '0;
                end
            end
            LOW: begin
                pad_clk = 1'b0;
                if (phase == HALF_LAST) begin
                    capture    = 1'b1;
                    state_next = HIGH;
                    phase_next = '0;
                end
            end
            HIGH: begin
                if (phase == HALF_LAST) begin
                    phase_next = '0;
                    if (n == 3'd7) begin
                        state_next = DONE;
                        publish    = 1'b1;
                    end else begin
                        n_next     = n + 3'd1;
                        state_next = LOW;
                    end
                end
            end
            DONE: begin
                valid      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_joy_reader.sv
// Randomized bench for joy_reader: behavioural pads plus a cycle-count model
// of the scan timeline checked every cycle.
module tb_joy_reader;
    localparam int HALF = 4;
    localparam int SCAN = 18 * HALF;

    logic       clock25 = 1'b0;
    logic       reset   = 1'b1;
    logic       poll    = 1'b0;
    logic       pad1_d, pad2_d;
    logic       pad_latch, pad_clk, valid, busy;
    logic [7:0] joy1, joy2;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit checks_on   = 1'b0;

    joy_reader #(.HALF(HALF)) dut (
        .clock25  (clock25),
        .reset    (reset),
        .poll     (poll),
        .pad1_d   (pad1_d),
        .pad2_d   (pad2_d),
        .pad_latch(pad_latch),
        .pad_clk  (pad_clk),
        .joy1     (joy1),
        .joy2     (joy2),
        .valid    (valid),
        .busy     (busy)
    );

    always #5 clock25 = ~clock25;

    // Controller model: parallel load while latched, shift on pad_clk rise, active-low data.
    logic [7:0] btn1 = 8'hAF, btn2 = 8'h3C;
    logic       disc1 = 1'b0, disc2 = 1'b0;
    logic [7:0] sr1 = 8'h00, sr2 = 8'h00;
    logic       prev_clk = 1'b1;

    always @(posedge clock25) begin
        prev_clk <= pad_clk;
        if (pad_latch) begin
            sr1 <= btn1;
            sr2 <= btn2;
        end else if (pad_clk && !prev_clk) begin
            sr1 <= {1'b0, sr1[7:1]};
            sr2 <= {1'b0, sr2[7:1]};
        end
    end

    assign pad1_d = disc1 ? 1'b1 : ~sr1[0];
    assign pad2_d = disc2 ? 1'b1 : ~sr2[0];

    // Reference: m_k counts cycles since the accepting edge; the whole scan follows from it.
    bit         m_scan = 1'b0;
    int         m_k    = 0;
    logic [7:0] m_joy1 = 8'h00, m_joy2 = 8'h00, m_exp1 = 8'h00, m_exp2 = 8'h00;

    always @(posedge clock25) begin
        cyc++;
        if (reset) begin
            m_scan = 1'b0;
            m_joy1 = 8'h00;
            m_joy2 = 8'h00;
        end else if (m_scan) begin
            m_k++;
            if (m_k == SCAN) begin
                m_joy1 = m_exp1;
                m_joy2 = m_exp2;
            end else if (m_k > SCAN) begin
                m_scan = 1'b0;
            end
        end else if (poll) begin
            m_scan = 1'b1;
            m_k    = 0;
            m_exp1 = disc1 ? 8'h00 : btn1;
            m_exp2 = disc2 ? 8'h00 : btn2;
        end
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, observed, expected);
        end
    endtask

    task automatic compareModel();
        logic e_latch, e_clk, e_valid;
        e_latch = m_scan && (m_k < 2 * HALF);
        e_clk   = !(m_scan && m_k >= 2 * HALF && m_k < SCAN && (((m_k - 2 * HALF) / HALF) % 2 == 0));
        e_valid = m_scan && (m_k == SCAN);
        checkOutput("busy", {7'd0, busy}, {7'd0, m_scan});
        checkOutput("pad_latch", {7'd0, pad_latch}, {7'd0, e_latch});
        checkOutput("pad_clk", {7'd0, pad_clk}, {7'd0, e_clk});
        checkOutput("valid", {7'd0, valid}, {7'd0, e_valid});
        checkOutput("joy1", joy1, m_joy1);
        checkOutput("joy2", joy2, m_joy2);
    endtask

    task automatic applyStimulus(input logic r, input logic p);
        @(negedge clock25);
        if (checks_on) compareModel();
        reset = r;
        poll  = p;
    endtask

    task automatic setPads(input logic [7:0] b1, input logic [7:0] b2,
                           input logic d1, input logic d2);
        @(negedge clock25);
        btn1  = b1;
        btn2  = b2;
        disc1 = d1;
        disc2 = d2;
    endtask

    initial begin
        repeat (3) applyStimulus(1'b1, 1'b0);
        checks_on = 1'b1;
        repeat (20) applyStimulus(1'b0, 1'b0);
        @(negedge clock25);
        checkOutput("rst_pad_clk", {7'd0, pad_clk}, 8'h01);
        checkOutput("rst_joy1", joy1, 8'h00);

        // Standard scan with distinct bytes per pad.
        setPads(8'hAF, 8'h3C, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        repeat (80) applyStimulus(1'b0, 1'b0);
        @(negedge clock25);
        checkOutput("scan_joy1_af", joy1, 8'hAF);
        checkOutput("scan_joy2_3c", joy2, 8'h3C);

        // Disconnected pad 2 reads as nothing pressed.
        setPads(8'h01, 8'hFF, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        repeat (80) applyStimulus(1'b0, 1'b0);
        @(negedge clock25);
        checkOutput("disc_joy1_01", joy1, 8'h01);
        checkOutput("disc_joy2_00", joy2, 8'h00);

        // Polls during the scan and in DONE are ignored; the cycle after DONE starts a new one.
        setPads(8'h5A, 8'hC3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        for (int i = 1; i <= 160; i++)
            applyStimulus(1'b0, (i == 10 || i == 40 || i == 73 || i == 74));

        // Poll held high: back-to-back scans, pad contents changing between them.
        for (int i = 0; i < 230; i++) begin
            if (!m_scan) begin
                btn1 = 8'($urandom);
                btn2 = 8'($urandom);
            end
            applyStimulus(1'b0, 1'b1);
        end
        repeat (80) applyStimulus(1'b0, 1'b0);

        // Reset mid-scan drops the previous result and aborts cleanly.
        setPads(8'hAF, 8'h3C, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        repeat (80) applyStimulus(1'b0, 1'b0);
        setPads(8'h77, 8'h88, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        repeat (40) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort_joy1", joy1, 8'h00);
        checkOutput("abort_busy", {7'd0, busy}, 8'h00);
        checkOutput("abort_latch", {7'd0, pad_latch}, 8'h00);
        applyStimulus(1'b0, 1'b1);
        repeat (80) applyStimulus(1'b0, 1'b0);
        @(negedge clock25);
        checkOutput("post_abort_joy1", joy1, 8'h77);

        // Random traffic: sporadic polls, occasional resets, pads changing while idle.
        for (int i = 0; i < 3000; i++) begin
            if (!m_scan && $urandom_range(0, 3) == 0) begin
                btn1  = 8'($urandom);
                btn2  = 8'($urandom);
                disc1 = ($urandom_range(0, 7) == 0);
                disc2 = ($urandom_range(0, 7) == 0);
            end
            applyStimulus($urandom_range(0, 599) == 0, $urandom_range(0, 7) == 0);
        end
        repeat (80) applyStimulus(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/joy_reader.md
# joy_reader

Serial gamepad scanner sitting directly upstream of the `ppu` block's `joy1` input (plus a second pad for the `joy2` path). On each `poll` request it drives the standard NES latch/clock protocol to both controller ports in parallel, shifts in eight buttons per pad, and presents them as stable, active-high bytes. The `ppu` samples `joy1`/`joy2` when the CPU reads $4016/$4017. The block runs in the `clock25` domain with no CPU involvement.

## Interface
- `HALF`, 150: half-period of `pad_clk` and the latch unit, in `clock25` cycles (150 = 6 µs at 25 MHz); legal range 4..1023.
- `clock25`  in  1  system clock (25 MHz); the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `poll`  in  1  scan request, single-cycle or level; sampled only in IDLE.
- `pad1_d`  in  1  pad 1 serial data, asynchronous, active-low (0 = pressed).
- `pad2_d`  in  1  pad 2 serial data, same rules.
- `pad_latch`  out  1  shared latch/strobe to both pads, active-high.
- `pad_clk`  out  1  shared shift clock to both pads, idles high.
- `joy1`  out  8  pad 1 buttons, 1 = pressed; bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
- `joy2`  out  8  pad 2 buttons, same mapping.
- `valid`  out  1  one-cycle pulse when `joy1`/`joy2` have just been updated.
- `busy`  out  1  high from poll acceptance through the DONE cycle.

## Operation
- `pad1_d` and `pad2_d` each pass through a 2-FF synchronizer. All sampling uses the synchronized values.
- State machine IDLE → LATCH → LOW → HIGH → (LOW…) → DONE → IDLE. It uses a phase counter of width ceil(log2(2·HALF)) and a 3-bit bit index `n`.
- IDLE: `pad_latch`=0, `pad_clk`=1, `busy`=0. When `poll`=1, go to LATCH, clear the phase counter, and set `n`=0.
- LATCH: `pad_latch`=1 for exactly 2·HALF cycles, then go to LOW.
- LOW: `pad_clk`=0 for HALF cycles. On the last LOW cycle, capture `sh1[n] <= ~sync1` and `sh2[n] <= ~sync2`. Then go to HIGH.
- HIGH: `pad_clk`=1 for HALF cycles. The rising edge advances the pad's shift register. At the end of HIGH: if `n`=7, go to DONE; otherwise increment `n` and go to LOW.
- DONE, one cycle: `joy1 <= sh1`, `joy2 <= sh2`, `valid`=1, `busy`=1. Then go to IDLE.
- `joy1`/`joy2` change only in DONE. Between scans they hold the last result, so the `ppu` never sees a partial byte.
- The shift registers `sh1`/`sh2` are internal and are not cleared between scans. All 8 bits are overwritten every scan.

## Timing
- Reset values: `pad_latch`=0, `pad_clk`=1, `joy1`=8'h00, `joy2`=8'h00, `valid`=0, `busy`=0; state = IDLE; synchronizers = 1.
- Reset asserted mid-scan aborts immediately. The next edge forces all reset values, and `joy1`/`joy2` drop to 0 (the previous result is not kept).
- If `poll` is sampled high at edge t in IDLE:
  - LATCH occupies cycles t+1 .. t+2·HALF.
  - Bit n's LOW phase starts at t+1+2·HALF+2n·HALF.
  - `valid`=1 and the new outputs appear in cycle t+1+18·HALF. With HALF=4 that is t+73.
  - `busy` rises in cycle t+1 and falls in cycle t+2+18·HALF.
- `poll` is ignored while `busy`=1, including the DONE cycle. A `poll` held high continuously rescans back-to-back, with exactly one IDLE cycle between scans.
- Synchronizer latency is 2 cycles. HALF ≥ 4 guarantees the captured value reflects the pad output at least 2 cycles after the preceding `pad_clk` rise or `pad_latch` fall.
- A disconnected pad (data pulled high) reads 8'h00.

## Test plan
- Reset, then idle 20 cycles → `pad_clk`=1, `pad_latch`=0, `joy1`=`joy2`=8'h00, `valid`=0, `busy`=0.
- HALF=4; pad models load 8'hAF (pad 1) and 8'h3C (pad 2) on latch, output ~bit0 first, and shift on `pad_clk` rise. Pulse `poll` at t → `pad_latch` high for cycles t+1..t+8, exactly 8 `pad_clk` low pulses of 4 cycles each, `valid` only at t+73, `joy1`=8'hAF, `joy2`=8'h3C.
- Pad 2 data tied high, pad 1 = 8'h01 → `joy2`=8'h00, `joy1`=8'h01 (A only).
- `poll` pulsed again at t+10, t+40 and in the DONE cycle → all ignored; a single `valid` pulse. A `poll` one cycle after DONE starts a new scan.
- `poll` held high for 200 cycles with HALF=4 → `valid` pulses at t+73 and t+147 (74-cycle period), plus at t+221 if still held.
- Assert `reset` at t+40 of a scan with prior `joy1`=8'hAF → next cycle `joy1`=8'h00, `pad_latch`=0, `pad_clk`=1, `busy`=0. After release, a fresh poll completes normally.
